// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin grant controller.
//   arb_state_e  : controller states (IDLE / GRANT / RELEASE)
//   HOLD_DISABLE : HOLD_MAX value that turns the hold-limit watchdog off
//   id_width()   : width of an owner index for N requesters (minimum 1)
//   cnt_width()  : width of the hold counter for a given HOLD_MAX (minimum 1)
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int HOLD_DISABLE = 0;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The counter only has to reach HOLD_MAX-1, so $clog2(HOLD_MAX+1) never
    // wraps before expiry; a disabled watchdog still gets a 1-bit counter.
    function automatic int cnt_width(input int hold_max);
        return (hold_max < 1) ? 1 : $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational wrap-around priority scan: returns the first requester at or
// after ptr, scanning upward modulo N.
//   req   [N]   : request vector
//   ptr   [IDW] : scan start index (always < N)
//   found       : at least one request present
//   idx   [IDW] : selected requester (0 when found=0)
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0] w_rot;   // req rotated so that bit 0 is the requester at ptr
    logic [IDW:0] w_sum;   // ptr + offset before the modulo-N fold

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rot = N'({req, req} >> ptr);
        found = 1'b0;
        w_sum = '0;
        // Scan from the far end down so the smallest offset is the one kept.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                w_sum = {1'b0, ptr} + (IDW + 1)'(k);
            end
        end
        if (w_sum >= (IDW + 1)'(N)) begin
            w_sum = w_sum - (IDW + 1)'(N);
        end
        idx = w_sum[IDW-1:0];
    end

endmodule

// File: rtl/arb_rr_ctrl.sv
// ---------------------------------------------------------------------------
// arb_rr_ctrl
// Round-robin grant controller for one shared resource. Issues at most one
// one-hot registered grant, inserts a single dead (RELEASE) cycle between
// owners, and reclaims the grant from an owner that holds it HOLD_MAX cycles.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   req  [N] : request level per requester
//   done [N] : release strobe per requester (only the owner's bit matters)
//   gnt  [N] : one-hot grant
//   gnt_id   : index of the current owner, holds its last value when idle
//   busy     : any grant bit high
//   timeout  : one-cycle pulse in the RELEASE cycle after a watchdog reclaim
// ---------------------------------------------------------------------------
module arb_rr_ctrl
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int IDW      = id_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    localparam int             HCW       = cnt_width(HOLD_MAX);
    localparam logic [HCW-1:0] HOLD_LAST =
        HCW'((HOLD_MAX == HOLD_DISABLE) ? 0 : HOLD_MAX - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

    arb_state_e     r_state;
    logic [IDW-1:0] r_ptr;
    logic [HCW-1:0] r_hold_cnt;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_timeout;

    arb_state_e     w_state_nxt;
    logic [IDW-1:0] w_ptr_nxt;
    logic [HCW-1:0] w_hold_nxt;
    logic [N-1:0]   w_gnt_nxt;
    logic [IDW-1:0] w_gnt_id_nxt;
    logic           w_timeout_nxt;

    logic           w_pick_found;
    logic [IDW-1:0] w_pick_idx;
    logic           w_own_release;
    logic           w_expire;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    // Only the owner's done/req bits can end a grant; everything else is
    // ignored while in GRANT.
    assign w_own_release = done[r_gnt_id] | ~req[r_gnt_id];
    assign w_expire      = (HOLD_MAX != HOLD_DISABLE) && (r_hold_cnt == HOLD_LAST);

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_timeout_nxt = 1'b0;

        unique case (r_state)
            IDLE, RELEASE: begin
                if (w_pick_found) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = N'(1) << w_pick_idx;
                    w_gnt_id_nxt = w_pick_idx;
                    w_hold_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_own_release || w_expire) begin
                    w_state_nxt = RELEASE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + 1'b1;
                    // A normal release on the expiry cycle wins: no pulse.
                    w_timeout_nxt = ~w_own_release;
                end else if (HOLD_MAX != HOLD_DISABLE) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // Outputs come straight from registers; busy is derived from the grant.
    always_comb begin
        gnt     = r_gnt;
        gnt_id  = r_gnt_id;
        busy    = |r_gnt;
        timeout = r_timeout;
    end

endmodule

// File: tb/tb_arb_rr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb_rr_ctrl
// Directed bench for arb_rr_ctrl (N=4, HOLD_MAX=8). A cycle-level model of
// the arbitration rules runs alongside the DUT; every stimulus step compares
// all outputs against it, and literal checks pin the expected sequence.
// ---------------------------------------------------------------------------
module tb_arb_rr_ctrl;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;
    localparam int IDW      = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    int n_vec = 0;
    int n_err = 0;

    arb_rr_ctrl #(
        .N        (N),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_owner: requester holding the resource, -1 when nobody does.
    // m_held : cycles the owner has already held it.
    int m_owner   = -1;
    int m_last_id = 0;
    int m_ptr     = 0;
    int m_held    = 0;
    bit m_timeout = 1'b0;

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner   = -1;
            m_last_id = 0;
            m_ptr     = 0;
            m_held    = 0;
            m_timeout = 1'b0;
        end else if (m_owner >= 0) begin
            m_held = m_held + 1;
            if (bit_of(done, m_owner) || !bit_of(req, m_owner)) begin
                m_ptr     = (m_owner + 1) % N;
                m_owner   = -1;
                m_timeout = 1'b0;
            end else if (HOLD_MAX != 0 && m_held == HOLD_MAX) begin
                m_ptr     = (m_owner + 1) % N;
                m_owner   = -1;
                m_timeout = 1'b1;
            end
        end else begin
            bit got;
            got       = 1'b0;
            m_timeout = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!got && bit_of(req, (m_ptr + k) % N)) begin
                    got       = 1'b1;
                    m_owner   = (m_ptr + k) % N;
                    m_last_id = m_owner;
                    m_held    = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic compare_model();
        logic [N-1:0] e_gnt;
        logic         e_busy;
        e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_busy = (m_owner >= 0);
        n_vec  = n_vec + 1;
        if (gnt !== e_gnt || gnt_id !== IDW'(m_last_id) || busy !== e_busy ||
            timeout !== m_timeout) begin
            n_err = n_err + 1;
            $display("FAIL model t=%0t: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                     $time, gnt, gnt_id, busy, timeout, e_gnt, m_last_id, e_busy, m_timeout);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    // Compare the outputs of the cycle just completed, then drive the inputs
    // that the next rising edge will sample.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        @(negedge clk);
        compare_model();
        req  = r;
        done = d;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: still running at %0t, want finish", $time);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 4'b0000;

        // Reset held for two cycles with every requester asking.
        step(4'b1111, 4'b0000);
        check("reset_gnt",     gnt,     32'h0);
        check("reset_busy",    busy,    32'h0);
        check("reset_timeout", timeout, 32'h0);
        check("reset_gnt_id",  gnt_id,  32'h0);
        step(4'b1111, 4'b0000);
        rst_n = 1'b1;
        step(4'b1111, 4'b0000);
        check("first_grant", gnt, 32'h1);

        // Rotation: each owner pulses done in its second cycle.
        for (int o = 0; o < N; o++) begin
            step(4'b1111, N'(1) << o);
            check("rot_hold", gnt, 32'(N'(1) << o));
            step(4'b1111, 4'b0000);
            check("rot_gap", gnt, 32'h0);
            check("rot_gap_busy", busy, 32'h0);
            step(4'b1111, 4'b0000);
            check("rot_next", gnt, 32'(N'(1) << ((o + 1) % N)));
        end

        // Owner 0 loses its request -> release, then wrap through holes.
        step(4'b1010, 4'b0000);
        check("drop_still_owner", gnt, 32'h1);
        step(4'b1010, 4'b0000);
        check("drop_release", gnt, 32'h0);
        check("drop_no_timeout", timeout, 32'h0);
        step(4'b1010, 4'b0010);
        check("holes_owner1", gnt, 32'h2);
        step(4'b1010, 4'b0000);
        check("holes_gap", gnt, 32'h0);
        step(4'b1010, 4'b1000);
        check("holes_owner3", gnt, 32'h8);
        check("holes_id3", gnt_id, 32'h3);
        step(4'b1010, 4'b0000);
        check("holes_gap_id_held", gnt_id, 32'h3);
        step(4'b1010, 4'b1000);
        check("holes_wrap_owner1", gnt, 32'h2);

        // done from a non-owner is ignored.
        step(4'b1010, 4'b0000);
        check("nonowner_done", gnt, 32'h2);

        // Watchdog on requester 2; requester 3 waits behind it.
        step(4'b1100, 4'b0000);
        check("pre_wd_owner1", gnt, 32'h2);
        step(4'b1100, 4'b0000);
        check("pre_wd_gap", gnt, 32'h0);
        for (int i = 0; i < HOLD_MAX; i++) begin
            step(4'b1100, 4'b0000);
            check("wd_hold", gnt, 32'h4);
            check("wd_hold_to", timeout, 32'h0);
        end
        step(4'b1100, 4'b0000);
        check("wd_expire_gnt", gnt, 32'h0);
        check("wd_expire_to", timeout, 32'h1);
        check("wd_expire_busy", busy, 32'h0);
        step(4'b1100, 4'b0000);
        check("wd_next_owner", gnt, 32'h8);
        check("wd_to_clear", timeout, 32'h0);

        // done on the expiry cycle: normal release, no pulse.
        for (int i = 2; i < HOLD_MAX; i++) begin
            step(4'b1100, 4'b0000);
        end
        step(4'b1100, 4'b1000);
        check("exp_done_last_cycle", gnt, 32'h8);
        step(4'b1000, 4'b0000);
        check("exp_done_gnt", gnt, 32'h0);
        check("exp_done_to", timeout, 32'h0);

        // Reset in the middle of a grant to requester 3.
        step(4'b1000, 4'b0000);
        check("pre_rst_owner3", gnt, 32'h8);
        check("pre_rst_id3", gnt_id, 32'h3);
        rst_n = 1'b0;
        req   = 4'b1010;
        step(4'b1010, 4'b0000);
        check("mid_rst_gnt", gnt, 32'h0);
        check("mid_rst_id", gnt_id, 32'h0);
        check("mid_rst_busy", busy, 32'h0);
        rst_n = 1'b1;
        step(4'b1010, 4'b0000);
        check("post_rst_lowest", gnt, 32'h2);
        check("post_rst_id", gnt_id, 32'h1);

        // Drain to idle.
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        check("drain_gap", gnt, 32'h0);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        check("idle_busy", busy, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
